// File: rtl/alu_iter_pkg.sv
// Shared types and op-classification helpers for the iterative execute-stage ALU.
// Op codes follow the core's alu_op_t decode; mul/div ops all live at 5'b10xxx.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'b00000,
    OP_SUB    = 5'b00001,
    OP_AND    = 5'b00010,
    OP_OR     = 5'b00011,
    OP_XOR    = 5'b00100,
    OP_SLT    = 5'b00101,
    OP_SLTU   = 5'b00110,
    OP_SLL    = 5'b00111,
    OP_SRL    = 5'b01000,
    OP_SRA    = 5'b01001,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return op[4:2] == 3'b101;
  endfunction

  function automatic logic is_signed_a(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Operand/result bus of the iterative ALU, including the pipeline flush.
// Both sides use valid/ready: a beat moves on the rising clk edge where valid & ready are both 1;
// valid may not depend on ready, and the producer holds its payload stable while valid=1 and ready=0.
interface alu_iter_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      op;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            ovf;

  modport master (
    output flush, in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero, ovf
  );

  modport slave (
    input  flush, in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero, ovf
  );
endinterface

// File: rtl/alu_iter_muldiv.sv
// Radix-2 multiply / restoring-divide datapath: XLEN steps after i_start, then one
// sign-fix cycle (o_done) where o_result holds the selected, sign-corrected value.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_flush,
  input  logic            i_start,
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_last,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  localparam int CNT_W = $clog2(XLEN);

  logic              r_busy;
  logic              r_fix;
  logic              r_neg;
  logic [1:0]        r_sel;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_quot;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_dvsr;

  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_abs;
  logic [XLEN-1:0]   w_b_abs;
  logic [1:0]        w_sel;
  logic [XLEN:0]     w_madd;
  logic [XLEN:0]     w_trial;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quot_fix;
  logic [XLEN-1:0]   w_rem_fix;

  assign w_a_neg = is_signed_a(i_op) & i_a[XLEN-1];
  assign w_b_neg = is_signed_b(i_op) & i_b[XLEN-1];
  assign w_a_abs = w_a_neg ? -i_a : i_a;
  assign w_b_abs = w_b_neg ? -i_b : i_b;

  // 0: low product, 1: high product, 2: quotient, 3: remainder
  always_comb begin
    w_sel = 2'd0;
    case (i_op)
      OP_MULH, OP_MULHSU, OP_MULHU: w_sel = 2'd1;
      OP_DIV, OP_DIVU:              w_sel = 2'd2;
      OP_REM, OP_REMU:              w_sel = 2'd3;
      default:                      w_sel = 2'd0;
    endcase
  end

  // The remainder stays below the divisor, so {rem, next bit} - divisor fits in XLEN+1 signed bits.
  assign w_madd  = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_trial = {r_rem, r_quot[XLEN-1]} - {1'b0, r_dvsr};

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_busy <= 1'b0;
      r_fix  <= 1'b0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_fix   <= 1'b0;
      r_cnt   <= CNT_W'(XLEN - 1);
      r_sel   <= w_sel;
      r_neg   <= (w_sel == 2'd3) ? w_a_neg : (w_a_neg ^ w_b_neg);
      r_prod  <= {{XLEN{1'b0}}, w_b_abs};
      r_mcand <= w_a_abs;
      r_quot  <= w_a_abs;
      r_rem   <= '0;
      r_dvsr  <= w_b_abs;
    end else if (r_busy) begin
      r_prod <= {w_madd, r_prod[XLEN-1:1]};
      if (!w_trial[XLEN]) begin
        r_rem  <= w_trial[XLEN-1:0];
        r_quot <= {r_quot[XLEN-2:0], 1'b1};
      end else begin
        r_rem  <= {r_rem[XLEN-2:0], r_quot[XLEN-1]};
        r_quot <= {r_quot[XLEN-2:0], 1'b0};
      end
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
        r_fix  <= 1'b1;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else begin
      r_fix <= 1'b0;
    end
  end

  assign w_prod_fix = r_neg ? -r_prod : r_prod;
  assign w_quot_fix = r_neg ? -r_quot : r_quot;
  assign w_rem_fix  = r_neg ? -r_rem  : r_rem;

  always_comb begin
    o_result = '0;
    case (r_sel)
      2'd0:    o_result = w_prod_fix[XLEN-1:0];
      2'd1:    o_result = w_prod_fix[2*XLEN-1:XLEN];
      2'd2:    o_result = w_quot_fix;
      default: o_result = w_rem_fix;
    endcase
  end

  assign o_last = r_busy & (r_cnt == '0);
  assign o_done = r_fix;

endmodule

// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle RV32I ops plus iterative RV32M mul/div behind a
// registered valid/ready handshake with flush. Division corner cases finish in one cycle.
module alu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  alu_iter_if.slave  bus,
  output state_t     o_state
);
  localparam int SHAMT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          r_state;
  logic            r_out_valid;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_ovf;

  logic               w_accept;
  logic               w_go_iter;
  logic               w_sub;
  logic               w_div_zero;
  logic               w_div_ovf;
  logic [XLEN-1:0]    w_b_inv;
  logic [XLEN-1:0]    w_sum;
  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0]    w_comb_result;
  logic               w_comb_ovf;
  logic               w_md_last;
  logic               w_md_done;
  logic [XLEN-1:0]    w_md_result;

  assign bus.in_ready = (r_state == IDLE) | ((r_state == DONE) & bus.out_ready);
  assign w_accept     = bus.in_valid & bus.in_ready & ~bus.flush;

  assign w_div_zero = is_div(bus.op) & (bus.b == '0);
  assign w_div_ovf  = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &
                      (bus.a == MOST_NEG) & (bus.b == '1);
  assign w_go_iter  = is_muldiv(bus.op) & ~w_div_zero & ~w_div_ovf;

  assign w_sub   = (bus.op == OP_SUB);
  assign w_b_inv = w_sub ? ~bus.b : bus.b;
  assign w_sum   = bus.a + w_b_inv + {{(XLEN-1){1'b0}}, w_sub};
  assign w_shamt = bus.b[SHAMT_W-1:0];

  assign w_comb_ovf = ((bus.op == OP_ADD) || w_sub) &
                      (bus.a[XLEN-1] == w_b_inv[XLEN-1]) & (w_sum[XLEN-1] != bus.a[XLEN-1]);

  // Only the divide corner cases reach this path among the mul/div codes.
  always_comb begin
    w_comb_result = '0;
    case (bus.op)
      OP_ADD, OP_SUB:  w_comb_result = w_sum;
      OP_AND:          w_comb_result = bus.a & bus.b;
      OP_OR:           w_comb_result = bus.a | bus.b;
      OP_XOR:          w_comb_result = bus.a ^ bus.b;
      OP_SLT:          w_comb_result = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OP_SLTU:         w_comb_result = {{(XLEN-1){1'b0}}, bus.a < bus.b};
      OP_SLL:          w_comb_result = bus.a << w_shamt;
      OP_SRL:          w_comb_result = bus.a >> w_shamt;
      OP_SRA:          w_comb_result = $signed(bus.a) >>> w_shamt;
      OP_DIV, OP_DIVU: w_comb_result = w_div_zero ? '1 : bus.a;
      OP_REM, OP_REMU: w_comb_result = w_div_zero ? bus.a : '0;
      default:         w_comb_result = '0;
    endcase
  end

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .i_flush  (bus.flush),
    .i_start  (w_accept & w_go_iter),
    .i_op     (bus.op),
    .i_a      (bus.a),
    .i_b      (bus.b),
    .o_last   (w_md_last),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_ovf       <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            if (w_go_iter) begin
              r_state     <= ITER;
              r_out_valid <= 1'b0;
            end else begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_comb_result;
              r_zero      <= (w_comb_result == '0);
              r_ovf       <= w_comb_ovf;
            end
          end else if ((r_state == DONE) && bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        ITER: begin
          if (w_md_last) r_state <= FIX;
        end
        FIX: begin
          if (w_md_done) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_md_result;
            r_zero      <= (w_md_result == '0);
            r_ovf       <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.ovf       = r_ovf;
  assign o_state       = r_state;

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: directed corner cases plus a random op stream, all scored against
// an arithmetic reference model through an expected-result queue.
module tb_alu_iter;
  import alu_pkg::*;

  localparam int XLEN   = 32;
  localparam int MD_LAT = XLEN + 2;

  logic   clk = 1'b0;
  logic   reset;
  state_t dbg_state;
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_err = 0;

  alu_iter_if #(.XLEN(XLEN)) bus ();

  alu_iter #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_res(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    logic [4:0]  sh;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    sh = b[4:0];
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd6:  return (a < b) ? 32'd1 : 32'd0;
      5'd7:  return a << sh;
      5'd8:  return a >> sh;
      5'd9:  return $signed(a) >>> sh;
      5'd16: begin p = ua * ub; return p[31:0];  end
      5'd17: begin p = sa * sb; return p[63:32]; end
      5'd18: begin p = sa * ub; return p[63:32]; end
      5'd19: begin p = ua * ub; return p[63:32]; end
      5'd20: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      5'd21: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      5'd22: begin
        if (b == 32'd0) return a;
        p = sa % sb; return p[31:0];
      end
      5'd23: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    longint      s;
    logic [31:0] lo;
    if (op == 5'd0)      s = longint'($signed(a)) + longint'($signed(b));
    else if (op == 5'd1) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    lo = s[31:0];
    return s != longint'($signed(lo));
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (op < 5'd16 || op > 5'd23) return 1;
    if (op >= 5'd20 && b == 32'd0) return 1;
    if ((op == 5'd20 || op == 5'd22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return MD_LAT;
  endfunction

  // ---------------- scoreboard ----------------
  logic [XLEN-1:0] exp_q[$];
  logic            exp_z_q[$];
  logic            exp_o_q[$];
  int              exp_lat_q[$];
  int              acc_cyc_q[$];
  logic            head_lat_done = 1'b0;

  always @(negedge clk) begin
    if (reset || bus.flush) begin
      exp_q.delete(); exp_z_q.delete(); exp_o_q.delete();
      exp_lat_q.delete(); acc_cyc_q.delete();
      head_lat_done = 1'b0;
    end else begin
      if (bus.out_valid && exp_q.size() == 0)
        chk("spurious_out_valid", bus.out_valid, 1'b0);
      if (bus.out_valid && exp_q.size() != 0 && !head_lat_done) begin
        chk("latency", cyc - acc_cyc_q[0], exp_lat_q[0]);
        head_lat_done = 1'b1;
      end
      if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
        chk("result", bus.result, exp_q.pop_front());
        chk("zero", bus.zero, exp_z_q.pop_front());
        chk("ovf", bus.ovf, exp_o_q.pop_front());
        void'(exp_lat_q.pop_front());
        void'(acc_cyc_q.pop_front());
        head_lat_done = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model_res(bus.op, bus.a, bus.b));
        exp_z_q.push_back(model_res(bus.op, bus.a, bus.b) == 32'd0);
        exp_o_q.push_back(model_ovf(bus.op, bus.a, bus.b));
        exp_lat_q.push_back(model_lat(bus.op, bus.a, bus.b));
        acc_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) chk("accept_timeout", bus.in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  logic [4:0] ops [20];
  logic       rand_en = 1'b0;
  int         seen;

  initial begin
    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
            5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd10, 5'd31};
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = 5'd0;
    bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_zero", bus.zero, 1'b1);
    chk("rst_ovf", bus.ovf, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_state", dbg_state, IDLE);
    @(posedge clk); #1;

    // simple ops back-to-back, out_ready held high
    send(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    send(OP_SUB, 32'd5, 32'd5);
    send(OP_SLT, 32'hFFFF_FFFF, 32'h1);
    send(OP_SLTU, 32'hFFFF_FFFF, 32'h1);
    send(OP_SRA, 32'h8000_0000, 32'd4);
    send(OP_SLL, 32'h0000_00F1, 32'h0000_0124);
    send(OP_SRL, 32'h8000_0000, 32'd31);
    send(OP_SUB, 32'h8000_0000, 32'd1);
    send(OP_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000);
    send(5'd13, 32'h1234_5678, 32'h1);
    idle();
    drain();

    // multiply, divide and divide corner cases
    send(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);    idle(); drain();
    send(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   idle(); drain();
    send(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  idle(); drain();
    send(OP_MULHSU, 32'hFFFF_FFFF, 32'h2);         idle(); drain();
    send(OP_DIV, -32'sd7, 32'd2);                  idle(); drain();
    send(OP_REM, -32'sd7, 32'd2);                  idle(); drain();
    send(OP_DIVU, 32'd100, 32'd7);                 idle(); drain();
    send(OP_REMU, 32'd100, 32'd7);                 idle(); drain();
    send(OP_DIV, 32'd5, 32'd0);
    send(OP_REM, 32'd5, 32'd0);
    send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    send(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(); drain();

    // backpressure: result held, no new accept
    bus.out_ready = 1'b0;
    send(OP_MUL, 32'h1234_5678, 32'h09AB_CDEF);
    idle();
    seen = 0;
    while (!bus.out_valid && seen < 100) begin @(negedge clk); seen++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("bp_out_valid", bus.out_valid, 1'b1);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      if (exp_q.size() != 0) chk("bp_result", bus.result, exp_q[0]);
      else chk("bp_queue", exp_q.size(), 1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drain();

    // flush in the 12th ITER cycle, with a competing in_valid
    send(OP_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    idle();
    step(11);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1; bus.op = OP_ADD; bus.a = 32'd1; bus.b = 32'd1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    idle();
    @(negedge clk);
    chk("flush_in_ready", bus.in_ready, 1'b1);
    chk("flush_out_valid", bus.out_valid, 1'b0);
    chk("flush_state", dbg_state, IDLE);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("flush_no_out_valid", seen, 0);
    @(posedge clk); #1;
    send(OP_ADD, 32'd2, 32'd3);
    idle(); drain();

    // reset mid-ITER with in_valid high, then accept straight after
    send(OP_DIVU, 32'hFFFF_0000, 32'd3);
    idle();
    step(10);
    reset = 1'b1;
    bus.in_valid = 1'b1; bus.op = OP_ADD; bus.a = 32'd4; bus.b = 32'd4;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.op = OP_ADD; bus.a = 32'd9; bus.b = 32'd1;
    @(negedge clk);
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_result", bus.result, 32'd0);
    chk("mid_rst_zero", bus.zero, 1'b1);
    chk("mid_rst_ovf", bus.ovf, 1'b0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    idle(); drain();

    // random stream with random backpressure
    rand_en = 1'b1;
    fork
      begin
        while (rand_en) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 60; i++) begin
      send(ops[$urandom_range(0, 19)], rand_opnd(), rand_opnd());
      if ($urandom_range(0, 2) == 0) begin
        idle();
        step($urandom_range(1, 3));
      end
    end
    idle();
    rand_en = 1'b0;
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    drain();
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
